sargantana_icache_bankway: RTL and testbench
============================================

SARGANTANA_ICACHE_BANKWAY -- requirements
Module: sargantana_icache_bankway

Interface
REQ-001 Parameters SHALL be as follows.
- SET_WIDTH, default 256: line width in bits.
- ADDR_WIDTH, default 6: index width; DEPTH = 2^ADDR_WIDTH entries.
- NUM_BANKS, default 4: byte-lane groups; BANK_W = SET_WIDTH/NUM_BANKS.
- INIT_ON_RESET, default 1: clear all entries after reset.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk_i, in, 1: single clock; all state on its rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- req_i, in, 1: access request.
- we_i, in, 1: 1 = write, 0 = read.
- be_i, in, NUM_BANKS: per-bank write enable.
- addr_i, in, ADDR_WIDTH: entry index.
- data_i, in, SET_WIDTH: write data.
- flush_i, in, 1: start invalidation sweep.
- ready_o, out, 1: block accepts requests.
- valid_o, out, 1: data_o carries read result.
- data_o, out, SET_WIDTH: read data.
REQ-003 Elaboration SHALL fail if SET_WIDTH % NUM_BANKS != 0 or NUM_BANKS < 1.

Function
REQ-004 Bank b SHALL map to bits [b*BANK_W +: BANK_W] of data_i, data_o and the storage.
REQ-005 FSM states SHALL be SWEEP (clearing) and IDLE; ready_o = 1 exactly in IDLE (registered, glitch-free).
REQ-006 Accepted request = req_i & ready_o at a rising edge; req_i while ready_o = 0 SHALL be ignored: no storage change, no valid_o.
REQ-007 Accepted write SHALL update only the banks with be_i[b] = 1 at addr_i; be_i = 0 is a legal no-op; valid_o is not asserted.
REQ-008 Accepted read SHALL present mem[addr_i] on data_o with valid_o = 1 in the cycle after acceptance (latency 1); valid_o SHALL be a single-cycle pulse per read.
REQ-009 Back-to-back reads SHALL sustain one result per cycle in request order.
REQ-010 data_o SHALL hold its last read value when valid_o = 0.
REQ-011 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-012 SWEEP SHALL use a counter that writes all-zero to entry cnt, one entry per cycle, from 0 to DEPTH-1.
- On the edge that writes entry DEPTH-1, the FSM SHALL go to IDLE.
- ready_o SHALL be low for exactly DEPTH cycles.
REQ-013 flush_i sampled high in IDLE SHALL enter SWEEP on that edge with cnt = 0.
REQ-014 If req_i and flush_i are both high in IDLE, the request SHALL be performed on that edge (a read's valid_o still pulses next cycle) and the sweep SHALL start on the same edge.
REQ-015 flush_i during SWEEP SHALL be ignored; the sweep is not restarted or extended.
REQ-016 Counter width SHALL be ADDR_WIDTH+1 or use explicit terminal detection; no wrap to 0 while in SWEEP.

Reset
REQ-017 rst_i SHALL asynchronously force valid_o = 0, data_o = 0 and cnt = 0.
REQ-018 With INIT_ON_RESET = 1, reset SHALL force state SWEEP and ready_o = 0; with INIT_ON_RESET = 0, it SHALL force state IDLE and ready_o = 1 (storage contents undefined).
REQ-019 Reset asserted mid-sweep SHALL restart the sweep from entry 0 after release.
REQ-020 No storage write SHALL occur while rst_i = 1.

Verification (SET_WIDTH=32, NUM_BANKS=4, ADDR_WIDTH=3, INIT_ON_RESET=1)
REQ-021 Release reset -> ready_o = 0 for 8 cycles, then 1; read addr 6 -> next cycle valid_o = 1, data_o = 0x00000000.
REQ-022 Write addr 5 0xAABBCCDD be=4'b1111, then write addr 5 0x11223344 be=4'b0101, then read addr 5 -> data_o = 0xAA22CC44.
REQ-023 Preload addr 1 = 0x1, addr 2 = 0x2; read 1 then 2 back-to-back -> valid_o high 2 consecutive cycles with data_o 0x1 then 0x2; afterwards valid_o = 0 and data_o holds 0x2.
REQ-024 Write addr 3 0xDEADBEEF with flush_i = 1 in the same cycle -> ready_o low 8 cycles; read addr 3 afterwards -> 0x00000000.
REQ-025 Assert rst_i when cnt = 4 -> ready_o = 0 immediately; after release ready_o stays low a full 8 cycles.
REQ-026 Drive req_i with write addr 0 0xFFFFFFFF while ready_o = 0 -> no valid_o; a later read of addr 0 returns 0x00000000.

Source files
------------

// File: rtl/sargantana_icache_bankway.sv
// ============================================================================
//  Module   : sargantana_icache_bankway
//  Brief    : One way of a banked instruction-cache data array. It holds
//             2^ADDR_WIDTH lines, supports per-bank partial writes and
//             1-cycle-latency reads, and clears every line with a sweep
//             after reset or on flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sargantana_icache_bankway #(
    parameter int SET_WIDTH     = 256,
    parameter int ADDR_WIDTH    = 6,
    parameter int NUM_BANKS     = 4,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [NUM_BANKS-1:0]  be_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [SET_WIDTH-1:0]  data_i,
    input  logic                  flush_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [SET_WIDTH-1:0]  data_o
);

    // Guarded divisor so a bad NUM_BANKS reaches the error below instead of
    // failing on a divide-by-zero first.
    localparam int c_num_banks_safe = (NUM_BANKS < 1) ? 1 : NUM_BANKS;
    localparam int c_bank_w         = SET_WIDTH / c_num_banks_safe;
    localparam int c_depth          = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] c_cnt_last = {ADDR_WIDTH{1'b1}};

    localparam logic [0:0] c_st_sweep = 1'b0;
    localparam logic [0:0] c_st_idle  = 1'b1;

    generate
        if ((NUM_BANKS < 1) || ((SET_WIDTH % c_num_banks_safe) != 0)) begin : g_param_err
            $error("sargantana_icache_bankway: SET_WIDTH must be a multiple of NUM_BANKS and NUM_BANKS >= 1");
        end
    endgenerate

    logic [0:0]            r_state;
    logic                  r_ready;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_cnt;

    logic                  w_accept;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_sweep;
    logic [ADDR_WIDTH-1:0] w_mem_addr;

    assign w_accept   = req_i & r_ready;
    assign w_rd       = w_accept & ~we_i;
    assign w_wr       = w_accept & we_i;
    assign w_sweep    = (r_state == c_st_sweep);
    // During a sweep the counter owns the write port; otherwise the request does.
    assign w_mem_addr = w_sweep ? r_cnt : addr_i;

    assign ready_o = r_ready;
    assign valid_o = r_valid;

    // Control FSM: sweep counter with terminal detection, registered ready and read-valid pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= INIT_ON_RESET ? c_st_sweep : c_st_idle;
            r_ready <= ~INIT_ON_RESET;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            case (r_state)
                c_st_sweep: begin
                    // flush_i is not looked at here, so a flush cannot restart or stretch the sweep.
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_idle;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // A request arriving with flush is served on this same edge by the datapath.
                    if (flush_i) begin
                        r_state <= c_st_sweep;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [c_bank_w-1:0] r_mem [c_depth];
            logic [c_bank_w-1:0] r_q;
            logic                w_we;
            logic [c_bank_w-1:0] w_wdata;

            assign w_we    = w_sweep | (w_wr & be_i[b]);
            assign w_wdata = w_sweep ? '0 : data_i[b*c_bank_w +: c_bank_w];

            // Bank storage: never reset, and no write lands while rst_i is asserted.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (!rst_i && w_we) begin
                    r_mem[w_mem_addr] <= w_wdata;
                end
            end

            // Read register: loads on an accepted read, otherwise holds the last result.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_q <= '0;
                end else if (w_rd) begin
                    r_q <= r_mem[addr_i];
                end
            end

            assign data_o[b*c_bank_w +: c_bank_w] = r_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_bankway.sv
// ============================================================================
//  Module   : tb_sargantana_icache_bankway
//  Brief    : Self-checking bench for sargantana_icache_bankway. It uses a
//             vector table for idle-state traffic, a read scoreboard keyed
//             by due cycle, and hand sequences for flush and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sargantana_icache_bankway;

    localparam int c_sw = 32;
    localparam int c_aw = 3;
    localparam int c_nb = 4;

    logic              clk_i   = 1'b0;
    logic              rst_i   = 1'b0;
    logic              req_i   = 1'b0;
    logic              we_i    = 1'b0;
    logic [c_nb-1:0]   be_i    = '0;
    logic [c_aw-1:0]   addr_i  = '0;
    logic [c_sw-1:0]   data_i  = '0;
    logic              flush_i = 1'b0;
    logic              ready_o;
    logic              valid_o;
    logic [c_sw-1:0]   data_o;

    sargantana_icache_bankway #(
        .SET_WIDTH    (c_sw),
        .ADDR_WIDTH   (c_aw),
        .NUM_BANKS    (c_nb),
        .INIT_ON_RESET(1'b1)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .be_i   (be_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .flush_i(flush_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .data_o (data_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [c_sw-1:0] data;
        int              due;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic            we;
        logic [c_nb-1:0] be;
        logic [c_aw-1:0] addr;
        logic [c_sw-1:0] data;
        logic [c_sw-1:0] exp;
    } vec_t;
    vec_t tbl[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every valid_o must match the oldest pending read in data and cycle.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
                check("read_data", 64'(data_o), 64'(sb[0].data));
                check("read_cycle", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("missing_valid", 64'(valid_o), 64'd1);
            void'(sb.pop_front());
        end
    end

    // One clock of stimulus; reads book their expected result for the next cycle.
    task automatic step(input logic rq, input logic we, input logic [c_nb-1:0] be,
                        input logic [c_aw-1:0] a, input logic [c_sw-1:0] d,
                        input logic fl, input logic [c_sw-1:0] exp);
        sb_t e;
        req_i = rq; we_i = we; be_i = be; addr_i = a; data_i = d; flush_i = fl;
        if (rq && !we) begin
            e.data = exp;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
    endtask

    // Counts rising edges until ready_o rises, holding whatever inputs the caller set.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        req_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        int n;

        tbl.push_back('{1'b0, 4'h0, 3'd6, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 4'hF, 3'd5, 32'hAABBCCDD, 32'h0});
        tbl.push_back('{1'b1, 4'h5, 3'd5, 32'h11223344, 32'h0});
        tbl.push_back('{1'b0, 4'h0, 3'd5, 32'h0,        32'hAA22CC44});
        tbl.push_back('{1'b1, 4'h8, 3'd4, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 3'd7, 32'h12345678, 32'h0});
        tbl.push_back('{1'b0, 4'h0, 3'd4, 32'h0,        32'hCA000000});
        tbl.push_back('{1'b0, 4'h0, 3'd7, 32'h0,        32'h0});
        tbl.push_back('{1'b1, 4'hF, 3'd1, 32'h1,        32'h0});
        tbl.push_back('{1'b1, 4'hF, 3'd2, 32'h2,        32'h0});
        tbl.push_back('{1'b0, 4'h0, 3'd1, 32'h0,        32'h1});
        tbl.push_back('{1'b0, 4'h0, 3'd2, 32'h0,        32'h2});

        // Reset state
        #2 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);

        // Initial sweep length
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_ready(n);
        check("init_sweep_cycles", 64'(n), 64'd8);

        // Idle traffic from the vector table, one record per cycle
        foreach (tbl[i]) begin
            check("table_ready", 64'(ready_o), 64'd1);
            step(1'b1, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].data, 1'b0, tbl[i].exp);
        end
        step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);
        check("hold_valid", 64'(valid_o), 64'd0);
        check("hold_data", 64'(data_o), 64'h2);

        // Write with flush on the same edge: write lands, then sweep clears it
        step(1'b1, 1'b1, 4'hF, 3'd3, 32'hDEADBEEF, 1'b1, 32'h0);
        wait_ready(n);
        check("flush_sweep_cycles", 64'(n), 64'd8);
        step(1'b1, 1'b0, 4'h0, 3'd3, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);

        // Read with flush: read served with old data; flush held during sweep is ignored
        step(1'b1, 1'b1, 4'hF, 3'd2, 32'h55, 1'b0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 3'd2, 32'h0, 1'b1, 32'h55);
        flush_i = 1'b1;
        wait_ready(n);
        check("flush_held_sweep_cycles", 64'(n), 64'd8);
        step(1'b1, 1'b0, 4'h0, 3'd2, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);

        // Reset in the middle of a sweep, with a write attempted while not ready
        step(1'b1, 1'b1, 4'hF, 3'd6, 32'h77, 1'b0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 3'd6, 32'h0, 1'b0, 32'h77);
        step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 32'h0);
        repeat (4) begin
            @(posedge clk_i);
            #1;
        end
        rst_i = 1'b1;
        #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_data", 64'(data_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 3'd0; data_i = 32'hFFFFFFFF;
        wait_ready(n);
        check("midrst_sweep_cycles", 64'(n), 64'd8);
        step(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 3'd6, 32'h0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 32'h0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
